// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential carry-save multiplier.
// Contents:
//   state_e    - controller state encoding (IDLE, BUSY, RESOLVE, DONE)
//   iter_count - number of BUSY cycles, ceil(width / bpc)
//   acc_width  - carry-save accumulator width, 2*width + 1
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic int unsigned iter_count(input int unsigned width,
                                               input int unsigned bpc);
        return (width + bpc - 1) / bpc;
    endfunction

    // One bit wider than the product so the carry-save pair never wraps mid-iteration.
    function automatic int unsigned acc_width(input int unsigned width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/seq_csa_mult_if.sv
// Operand/result handshake bundle for seq_csa_mult.
// Signals:
//   in_valid/in_ready   - operand handshake (x, y)
//   abort               - cancel the operation in flight
//   out_valid/out_ready - result handshake (product, 2*WIDTH bits)
// Modports: master drives operands and consumes results; slave is the multiplier.
interface seq_csa_mult_if #(
    parameter int unsigned WIDTH = 11
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 abort;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, x, y, abort, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, x, y, abort, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/csa_row.sv
// W-bit 3:2 compressor row built from full_adder cells.
// Ports:
//   a_i, b_i, c_i - three W-bit addends
//   sum_o         - bitwise XOR of the addends
//   carry_o       - bitwise majority shifted left by one (MSB majority dropped)
// sum_o + carry_o == a_i + b_i + c_i modulo 2^W.
module csa_row #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    logic [W-1:0] maj;

    for (genvar k = 0; k < W; k++) begin : g_fa
        full_adder u_fa (
            .a_i  (a_i[k]),
            .b_i  (b_i[k]),
            .ci_i (c_i[k]),
            .s_o  (sum_o[k]),
            .co_o (maj[k])
        );
    end

    assign carry_o = {maj[W-2:0], 1'b0};

    // Top majority bit falls off the accumulator; callers size W so it is always zero.
    logic unused_maj_msb;
    assign unused_maj_msb = maj[W-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Ports:
//   a_i, b_i, ci_i - addend bits and carry in
//   s_o            - sum bit
//   co_o           - carry out (majority of the three inputs)
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/seq_csa_mult.sv
// Iterative unsigned multiplier: retires BITS_PER_CYCLE partial-product rows per
// cycle into a carry-save accumulator, then resolves with one carry-propagate add.
// Ports:
//   clk     - clock, rising edge
//   reset_n - synchronous active-low reset
//   bus     - seq_csa_mult_if.slave: in_valid/in_ready/x/y, abort,
//             out_valid/out_ready/product (2*WIDTH bits, exact x*y)
// Latency from the accept edge to out_valid: ITER + 1 edges.
module seq_csa_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH          = 11,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    seq_csa_mult_if.slave bus
);

    localparam int unsigned ITER  = iter_count(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned ACC_W = acc_width(WIDTH);
    localparam int unsigned YW    = ITER * BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   x_sh_q;      // multiplicand pre-shifted by count*BITS_PER_CYCLE
    logic [YW-1:0]      y_sh_q;      // multiplier, consumed LSB first
    logic [ACC_W-1:0]   sum_q;
    logic [ACC_W-1:0]   carry_q;
    logic [CNT_W-1:0]   count_q;
    logic [2*WIDTH-1:0] product_q;

    // Carry-save chain: one 3:2 row per partial product retired this cycle.
    logic [ACC_W-1:0] s_chain [BITS_PER_CYCLE+1];
    logic [ACC_W-1:0] c_chain [BITS_PER_CYCLE+1];
    logic [ACC_W-1:0] row     [BITS_PER_CYCLE];

    assign s_chain[0] = sum_q;
    assign c_chain[0] = carry_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_rows
        assign row[i] = y_sh_q[i] ? (x_sh_q << i) : '0;

        csa_row #(
            .W (ACC_W)
        ) u_csa (
            .a_i     (s_chain[i]),
            .b_i     (c_chain[i]),
            .c_i     (row[i]),
            .sum_o   (s_chain[i+1]),
            .carry_o (c_chain[i+1])
        );
    end

    // Final carry-propagate add; only the low 2*WIDTH bits are meaningful.
    logic [ACC_W-1:0] cpa;
    assign cpa = sum_q + carry_q;

    logic unused_cpa_msb;
    assign unused_cpa_msb = cpa[ACC_W-1];

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                // abort alongside in_valid is ignored: the operands are taken.
                if (bus.in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (bus.abort)            state_d = IDLE;
                else if (count_q == LAST) state_d = RESOLVE;
            end
            RESOLVE: begin
                state_d = bus.abort ? IDLE : DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    assign bus.product = product_q;

    // Datapath
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_sh_q    <= '0;
            y_sh_q    <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_sh_q  <= ACC_W'(bus.x);
                        y_sh_q  <= YW'(bus.y);
                        sum_q   <= '0;
                        carry_q <= '0;
                        count_q <= '0;
                    end
                end
                BUSY: begin
                    if (!bus.abort) begin
                        sum_q   <= s_chain[BITS_PER_CYCLE];
                        carry_q <= c_chain[BITS_PER_CYCLE];
                        x_sh_q  <= x_sh_q << BITS_PER_CYCLE;
                        y_sh_q  <= y_sh_q >> BITS_PER_CYCLE;
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                RESOLVE: begin
                    if (!bus.abort) product_q <= cpa[2*WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_csa_mult.sv
// Bench for seq_csa_mult: three builds (11/1, 11/4, 16/3) share clock and reset.
// Directed scenarios run on the 11/1 build; random operands with output stalls
// run on the 11/4 and 16/3 builds against a plain x*y model.
module tb_seq_csa_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Per-build stimulus/response, index 0: 11/1, 1: 11/4, 2: 16/3
    logic        iv   [3];
    logic        ab   [3];
    logic        ordy [3];
    logic [63:0] xv   [3];
    logic [63:0] yv   [3];
    logic        irdy [3];
    logic        ovld [3];
    logic [63:0] prod [3];

    seq_csa_mult_if #(.WIDTH(11)) bus0 ();
    seq_csa_mult_if #(.WIDTH(11)) bus1 ();
    seq_csa_mult_if #(.WIDTH(16)) bus2 ();

    assign bus0.in_valid  = iv[0];
    assign bus0.abort     = ab[0];
    assign bus0.out_ready = ordy[0];
    assign bus0.x         = xv[0][10:0];
    assign bus0.y         = yv[0][10:0];
    assign irdy[0]        = bus0.in_ready;
    assign ovld[0]        = bus0.out_valid;
    assign prod[0]        = 64'(bus0.product);

    assign bus1.in_valid  = iv[1];
    assign bus1.abort     = ab[1];
    assign bus1.out_ready = ordy[1];
    assign bus1.x         = xv[1][10:0];
    assign bus1.y         = yv[1][10:0];
    assign irdy[1]        = bus1.in_ready;
    assign ovld[1]        = bus1.out_valid;
    assign prod[1]        = 64'(bus1.product);

    assign bus2.in_valid  = iv[2];
    assign bus2.abort     = ab[2];
    assign bus2.out_ready = ordy[2];
    assign bus2.x         = xv[2][15:0];
    assign bus2.y         = yv[2][15:0];
    assign irdy[2]        = bus2.in_ready;
    assign ovld[2]        = bus2.out_valid;
    assign prod[2]        = 64'(bus2.product);

    seq_csa_mult #(.WIDTH(11), .BITS_PER_CYCLE(1)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    seq_csa_mult #(.WIDTH(11), .BITS_PER_CYCLE(4)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    seq_csa_mult #(.WIDTH(16), .BITS_PER_CYCLE(3)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    // Reference model: exact unsigned product of the operands truncated to the build width.
    function automatic int width_of(input int d);
        return (d == 2) ? 16 : 11;
    endfunction

    function automatic logic [63:0] ref_mul(input int d, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [63:0] m;
        m = (64'd1 << width_of(d)) - 64'd1;
        return (a & m) * (b & m);
    endfunction

    // Expected accept-edge to out_valid latency for each build.
    function automatic int lat_of(input int d);
        return (d == 0) ? 12 : ((d == 1) ? 4 : 7);
    endfunction

    task automatic start_op(input int d, input logic [63:0] a, input logic [63:0] b,
                            input logic with_abort);
        @(negedge clk);
        n_checks++;
        if (irdy[d] !== 1'b1) begin
            $display("FAIL in_ready_before_accept dut%0d: got %b want 1", d, irdy[d]);
            n_fail++;
        end
        xv[d] = a;
        yv[d] = b;
        iv[d] = 1'b1;
        ab[d] = with_abort;
        @(negedge clk);
        iv[d] = 1'b0;
        ab[d] = 1'b0;
        // Operands must be frozen inside the block after capture.
        xv[d] = {$urandom, $urandom};
        yv[d] = {$urandom, $urandom};
    endtask

    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        while (ovld[d] !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
            xv[d] = {$urandom, $urandom};
            yv[d] = {$urandom, $urandom};
        end
        n_checks++;
        if (ovld[d] !== 1'b1) begin
            $display("FAIL out_valid_timeout dut%0d: got %b want 1 within 64 cycles",
                     d, ovld[d]);
            n_fail++;
        end
    endtask

    task automatic take(input int d);
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        n_checks++;
        if (ovld[d] !== 1'b0 || irdy[d] !== 1'b1) begin
            $display("FAIL handshake_to_idle dut%0d: got out_valid=%b in_ready=%b want 0/1",
                     d, ovld[d], irdy[d]);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (irdy[d] !== 1'b1) begin
                $display("FAIL reset_in_ready dut%0d: got %b want 1", d, irdy[d]);
                n_fail++;
            end
            n_checks++;
            if (ovld[d] !== 1'b0) begin
                $display("FAIL reset_out_valid dut%0d: got %b want 0", d, ovld[d]);
                n_fail++;
            end
            n_checks++;
            if (prod[d] !== 64'd0) begin
                $display("FAIL reset_product dut%0d: got %0h want 0", d, prod[d]);
                n_fail++;
            end
        end
    endtask

    task automatic test_directed();
        logic [63:0] ta [3];
        logic [63:0] tb [3];
        logic [63:0] te [3];
        int          lat;
        ta = '{64'h7FF, 64'h400, 64'h000};
        tb = '{64'h7FF, 64'h400, 64'h5A5};
        te = '{64'h3FF001, 64'h100000, 64'h0};
        for (int k = 0; k < 3; k++) begin
            start_op(0, ta[k], tb[k], 1'b0);
            wait_valid(0, lat);
            n_checks++;
            if (prod[0] !== te[k]) begin
                $display("FAIL directed_product[%0d]: got %0h want %0h", k, prod[0], te[k]);
                n_fail++;
            end
            n_checks++;
            if (lat != 12) begin
                $display("FAIL directed_latency[%0d]: got %0d want 12", k, lat);
                n_fail++;
            end
            take(0);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(0, 64'd5, 64'd7, 1'b0);
        wait_valid(0, lat);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (prod[0] !== 64'd35 || irdy[0] !== 1'b0 || ovld[0] !== 1'b1) begin
                $display("FAIL backpressure_hold[%0d]: got product=%0h in_ready=%b out_valid=%b want 23/0/1",
                         k, prod[0], irdy[0], ovld[0]);
                n_fail++;
            end
            // abort while DONE must not drop the result
            ab[0] = (k == 2);
            @(negedge clk);
        end
        ab[0] = 1'b0;
        n_checks++;
        if (ovld[0] !== 1'b1 || prod[0] !== 64'd35) begin
            $display("FAIL abort_in_done: got out_valid=%b product=%0h want 1/23",
                     ovld[0], prod[0]);
            n_fail++;
        end
        take(0);
    endtask

    task automatic test_abort();
        int   lat;
        logic seen_valid;
        start_op(0, 64'h7FF, 64'h7FF, 1'b0);
        repeat (3) @(negedge clk);
        ab[0] = 1'b1;                 // sampled during the 4th BUSY cycle
        @(negedge clk);
        ab[0] = 1'b0;
        n_checks++;
        if (irdy[0] !== 1'b1 || ovld[0] !== 1'b0 || prod[0] !== 64'd35) begin
            $display("FAIL abort_busy: got in_ready=%b out_valid=%b product=%0h want 1/0/23",
                     irdy[0], ovld[0], prod[0]);
            n_fail++;
        end
        seen_valid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (ovld[0] === 1'b1) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid !== 1'b0) begin
            $display("FAIL abort_no_result: got out_valid seen=%b want 0", seen_valid);
            n_fail++;
        end
        // abort together with in_valid in IDLE: operands still accepted
        start_op(0, 64'd3, 64'd5, 1'b1);
        wait_valid(0, lat);
        n_checks++;
        if (prod[0] !== 64'd15 || lat != 12) begin
            $display("FAIL after_abort_op: got product=%0h latency=%0d want f/12", prod[0], lat);
            n_fail++;
        end
        take(0);
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(0, 64'h7FF, 64'h7FF, 1'b0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_checks++;
        if (ovld[0] !== 1'b0 || prod[0] !== 64'd0) begin
            $display("FAIL reset_mid_busy: got out_valid=%b product=%0h want 0/0",
                     ovld[0], prod[0]);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (irdy[0] !== 1'b1) begin
            $display("FAIL reset_mid_in_ready: got %b want 1", irdy[0]);
            n_fail++;
        end
        start_op(0, 64'h123, 64'h456, 1'b0);
        wait_valid(0, lat);
        n_checks++;
        if (prod[0] !== 64'h04EDC2 || lat != 12) begin
            $display("FAIL reset_mid_next_op: got product=%0h latency=%0d want 4edc2/12",
                     prod[0], lat);
            n_fail++;
        end
        take(0);
    endtask

    task automatic test_random(input int d, input int n);
        logic [63:0] a, b, m, expv;
        int          lat, mode, stall;
        m = (64'd1 << width_of(d)) - 64'd1;
        for (int k = 0; k < n; k++) begin
            mode = $urandom_range(0, 7);
            a = {$urandom, $urandom} & m;
            b = {$urandom, $urandom} & m;
            if (k == 0 || mode == 2) begin
                a = m;
                b = m;
            end else if (mode == 0) begin
                a = 64'd0;
            end else if (mode == 1) begin
                b = 64'd0;
            end
            expv = ref_mul(d, a, b);
            start_op(d, a, b, 1'b0);
            wait_valid(d, lat);
            n_checks++;
            if (lat != lat_of(d)) begin
                $display("FAIL random_latency dut%0d op%0d: got %0d want %0d",
                         d, k, lat, lat_of(d));
                n_fail++;
            end
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clk);
            n_checks++;
            if (prod[d] !== expv || ovld[d] !== 1'b1) begin
                $display("FAIL random_product dut%0d op%0d (%0h*%0h): got %0h valid=%b want %0h",
                         d, k, a, b, prod[d], ovld[d], expv);
                n_fail++;
            end
            take(d);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            ab[d]   = 1'b0;
            ordy[d] = 1'b0;
            xv[d]   = 64'd0;
            yv[d]   = 64'd0;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_random(1, 2000);
        test_random(2, 2000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
